// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for a 5-stage RV32I pipeline. It latches the
//   decoded instruction and its operands at the end of ID. It forwards
//   results from EX/MEM and MEM/WB into the latched rs1/rs2 values. It picks
//   the two ALU operands. It also detects load-use hazards: in that case it
//   inserts a bubble into EX and holds IF/ID.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   id_valid/id_inst/id_pc     instruction currently in ID
//   id_rs1_data/id_rs2_data    register-file read data for the ID instruction
//   id_imm                     sign-extended immediate for the ID instruction
//   flush                      squash the ID->EX transfer (redirect from EX)
//   exmem_* / memwb_*          write-back info used for forwarding
//   ex_valid/ex_inst/ex_pc     instruction currently in EX
//   alu_in_1/alu_in_2          ALU operands
//   ex_store_data              forwarded rs2 value for stores
//   stall_id                   hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        ex_valid,
    output logic [31:0] ex_inst,
    output logic [31:0] ex_pc,
    output logic [31:0] alu_in_1,
    output logic [31:0] alu_in_2,
    output logic [31:0] ex_store_data,
    output logic        stall_id
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0] rs1_data_reg;
    logic [31:0] rs2_data_reg;
    logic [31:0] imm_reg;

    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [6:0] ex_opcode;
    logic [4:0] ex_rd;

    assign id_opcode = id_inst[6:0];
    assign id_rs1    = id_inst[19:15];
    assign id_rs2    = id_inst[24:20];
    assign ex_opcode = ex_inst[6:0];
    assign ex_rd     = ex_inst[11:7];

    // ------------------------------------------------------------------
    // Load-use hazard: a load in EX whose destination feeds the ID
    // instruction cannot be forwarded in time, so one bubble is inserted.
    // ------------------------------------------------------------------
    logic rs1_used;
    logic rs2_used;

    always_comb begin
        rs1_used = (id_opcode != OP_JAL);
        rs2_used = (id_opcode == OP_R) || (id_opcode == OP_STORE) ||
                   (id_opcode == OP_BRANCH);
        stall_id = ex_valid && (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                   id_valid &&
                   ((rs1_used && (id_rs1 == ex_rd)) ||
                    (rs2_used && (id_rs2 == ex_rd)));
    end

    // ------------------------------------------------------------------
    // Pipeline register. Both flush and a load-use stall insert the same
    // bubble. The bubble is a NOP that writes no register, so the stages
    // downstream stay inert.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_inst      <= NOP_INST;
            ex_pc        <= RESET_PC;
            rs1_data_reg <= 32'h0;
            rs2_data_reg <= 32'h0;
            imm_reg      <= 32'h0;
        end else if (flush || stall_id) begin
            ex_valid     <= 1'b0;
            ex_inst      <= NOP_INST;
            ex_pc        <= RESET_PC;
            rs1_data_reg <= 32'h0;
            rs2_data_reg <= 32'h0;
            imm_reg      <= 32'h0;
        end else begin
            ex_valid     <= id_valid;
            ex_inst      <= id_valid ? id_inst : NOP_INST;
            ex_pc        <= id_pc;
            rs1_data_reg <= id_rs1_data;
            rs2_data_reg <= id_rs2_data;
            imm_reg      <= id_imm;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding. Index 0 is rs1 and index 1 is rs2. EX/MEM is younger, so
    // it wins over MEM/WB. x0 is never forwarded.
    // ------------------------------------------------------------------
    logic [4:0]  src_idx  [2];
    logic [31:0] lat_data [2];
    logic [31:0] fwd_data [2];

    assign src_idx[0]  = ex_inst[19:15];
    assign src_idx[1]  = ex_inst[24:20];
    assign lat_data[0] = rs1_data_reg;
    assign lat_data[1] = rs2_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_data[gi] =
                (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == src_idx[gi])) ? exmem_result :
                (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == src_idx[gi])) ? memwb_result :
                lat_data[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand select
    // ------------------------------------------------------------------
    always_comb begin
        alu_in_1 = (ex_opcode == OP_JAL) ? ex_pc : fwd_data[0];
        case (ex_opcode)
            OP_R, OP_BRANCH:                        alu_in_2 = fwd_data[1];
            OP_I, OP_LOAD, OP_STORE, OP_JALR, OP_JAL: alu_in_2 = imm_reg;
            default:                                alu_in_2 = 32'h0;
        endcase
    end

    assign ex_store_data = fwd_data[1];

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        ex_valid;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic [31:0] alu_in_1;
    logic [31:0] alu_in_2;
    logic [31:0] ex_store_data;
    logic        stall_id;

    int total = 0;
    int bad   = 0;
    int txn_n = 0;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ADD_312 = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] ADDI_73 = 32'h0051_8393; // addi x7,x3,5
    localparam logic [31:0] ADDI_90 = 32'h0070_0493; // addi x9,x0,7
    localparam logic [31:0] LW_5    = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD_651 = 32'h0012_8333; // add  x6,x5,x1
    localparam logic [31:0] JAL_1   = 32'h0000_00EF; // jal  x1,...
    localparam logic [31:0] SW_21   = 32'h0020_A223; // sw   x2,4(x1)
    localparam logic [31:0] SW_51   = 32'h0050_A023; // sw   x5,0(x1)
    localparam logic [31:0] BEQ_12  = 32'h0020_8063; // beq  x1,x2,...
    localparam logic [31:0] LUI_8   = 32'h1234_5437; // lui  x8,0x12345

    id_ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .ex_inst         (ex_inst),
        .ex_pc           (ex_pc),
        .alu_in_1        (alu_in_1),
        .alu_in_2        (alu_in_2),
        .ex_store_data   (ex_store_data),
        .stall_id        (stall_id)
    );

    always #5 clk = ~clk;

    // Expected EX-stage view of one instruction, plus the forwarding inputs
    // to present while that instruction sits in EX.
    typedef struct {
        logic        v;
        logic [31:0] inst, pc, a1, a2, sd;
        logic        xwe;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wres;
    } txn_t;

    txn_t sb[$];

    function automatic txn_t mk(input logic v, input logic [31:0] inst, pc, a1, a2, sd,
                                input logic xwe, input logic [4:0] xrd, input logic [31:0] xres,
                                input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
        txn_t t;
        t.v = v; t.inst = inst; t.pc = pc; t.a1 = a1; t.a2 = a2; t.sd = sd;
        t.xwe = xwe; t.xrd = xrd; t.xres = xres;
        t.wwe = wwe; t.wrd = wrd; t.wres = wres;
        return t;
    endfunction

    function automatic txn_t bub();
        return mk(1'b0, NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;
    endtask

    // Pop the instruction now in EX, apply its forwarding inputs, compare.
    task automatic pop_check();
        txn_t t;
        t = sb.pop_front();
        exmem_reg_write = t.xwe; exmem_rd = t.xrd; exmem_result = t.xres;
        memwb_reg_write = t.wwe; memwb_rd = t.wrd; memwb_result = t.wres;
        #1;
        check("ex_valid", {31'h0, ex_valid}, {31'h0, t.v});
        check("ex_inst", ex_inst, t.inst);
        check("ex_pc", ex_pc, t.pc);
        check("alu_in_1", alu_in_1, t.a1);
        check("alu_in_2", alu_in_2, t.a2);
        check("ex_store_data", ex_store_data, t.sd);
        $display("txn %0d: inst=%h pc=%h a1=%h a2=%h sd=%h v=%0d",
                 txn_n, ex_inst, ex_pc, alu_in_1, alu_in_2, ex_store_data, ex_valid);
        txn_n++;
    endtask

    // One clock cycle: check EX, drive ID, check stall, queue the expected
    // EX content for the next cycle, then advance to the next falling edge.
    task automatic step(input logic v, input logic [31:0] inst, pc, r1, r2, imm,
                        input logic fl, input logic exp_stall, input txn_t nxt);
        if (sb.size() > 0) pop_check();
        else clear_fwd();
        id_valid = v; id_inst = inst; id_pc = pc;
        id_rs1_data = r1; id_rs2_data = r2; id_imm = imm; flush = fl;
        #1;
        check("stall_id", {31'h0, stall_id}, {31'h0, exp_stall});
        sb.push_back(nxt);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_ex_valid"}, {31'h0, ex_valid}, 32'h0);
        check({pfx, "_ex_inst"}, ex_inst, NOP);
        check({pfx, "_ex_pc"}, ex_pc, 32'h0);
        check({pfx, "_alu_in_1"}, alu_in_1, 32'h0);
        check({pfx, "_alu_in_2"}, alu_in_2, 32'h0);
        check({pfx, "_store"}, ex_store_data, 32'h0);
        check({pfx, "_stall"}, {31'h0, stall_id}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        id_valid = 1'b0; id_inst = 32'h0; id_pc = 32'h0;
        id_rs1_data = 32'h0; id_rs2_data = 32'h0; id_imm = 32'h0; flush = 1'b0;
        clear_fwd();
        #2;
        check_reset_state("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted mid-cycle while EX holds a real instruction.
        step(1'b1, ADD_312, 32'h80, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0,
             mk(1'b1, ADD_312, 32'h80, 32'h5, 32'h7, 32'h7, 0, 0, 0, 0, 0, 0));
        pop_check();
        id_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Plain add, no hazards.
        step(1'b1, ADD_312, 32'h100, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0,
             mk(1'b1, ADD_312, 32'h100, 32'h5, 32'h7, 32'h7, 0, 0, 0, 0, 0, 0));
        // addi x7,x3: EX/MEM and MEM/WB both target x3; EX/MEM wins.
        step(1'b1, ADDI_73, 32'h104, 32'h0, 32'h99, 32'h5, 1'b0, 1'b0,
             mk(1'b1, ADDI_73, 32'h104, 32'h10, 32'h5, 32'h99, 1, 5'd3, 32'h10, 1, 5'd3, 32'h20));
        // add x3,x1,x2: rs2 from EX/MEM, rs1 from MEM/WB.
        step(1'b1, ADD_312, 32'h108, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0,
             mk(1'b1, ADD_312, 32'h108, 32'hBB, 32'hAA, 32'hAA, 1, 5'd2, 32'hAA, 1, 5'd1, 32'hBB));
        // addi x9,x0,7: writers to x0 must never be forwarded.
        step(1'b1, ADDI_90, 32'h10C, 32'h0, 32'h0, 32'h7, 1'b0, 1'b0,
             mk(1'b1, ADDI_90, 32'h10C, 32'h0, 32'h7, 32'h0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hEEEE));
        // lw x5 then dependent add x6,x5,x1: one stall, one bubble.
        step(1'b1, LW_5, 32'h200, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0,
             mk(1'b1, LW_5, 32'h200, 32'h40, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0));
        step(1'b1, ADD_651, 32'h204, 32'h0, 32'h3, 32'h0, 1'b0, 1'b1, bub());
        step(1'b1, ADD_651, 32'h204, 32'h0, 32'h3, 32'h0, 1'b0, 1'b0,
             mk(1'b1, ADD_651, 32'h204, 32'h55, 32'h3, 32'h3, 0, 0, 0, 1, 5'd5, 32'h55));
        // JAL: operand 1 is the PC and operand 2 is the immediate.
        step(1'b1, JAL_1, 32'h300, 32'h77, 32'h66, 32'h100, 1'b0, 1'b0,
             mk(1'b1, JAL_1, 32'h300, 32'h300, 32'h100, 32'h66, 0, 0, 0, 0, 0, 0));
        // Flush with a valid ID instruction gives a bubble.
        step(1'b1, ADD_312, 32'h304, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, bub());
        // Store: imm operand, store data forwarded from EX/MEM.
        step(1'b1, SW_21, 32'h308, 32'h1000, 32'hDEAD, 32'h4, 1'b0, 1'b0,
             mk(1'b1, SW_21, 32'h308, 32'h1000, 32'h4, 32'hBEEF, 1, 5'd2, 32'hBEEF, 0, 0, 0));
        // Branch: rs2 as operand 2, rs1 from MEM/WB.
        step(1'b1, BEQ_12, 32'h30C, 32'h9, 32'h9, 32'h8, 1'b0, 1'b0,
             mk(1'b1, BEQ_12, 32'h30C, 32'h3, 32'h9, 32'h9, 0, 0, 0, 1, 5'd1, 32'h3));
        // LUI: any other opcode gives operand 2 = 0.
        step(1'b1, LUI_8, 32'h310, 32'h11, 32'h22, 32'h1234_5000, 1'b0, 1'b0,
             mk(1'b1, LUI_8, 32'h310, 32'h11, 32'h0, 32'h22, 0, 0, 0, 0, 0, 0));
        // id_valid=0 latches a NOP.
        step(1'b0, ADD_312, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, bub());
        // lw x5 then sw x5 (rs2 hazard) while flush is also high.
        step(1'b1, LW_5, 32'h400, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0,
             mk(1'b1, LW_5, 32'h400, 32'h40, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0));
        step(1'b1, SW_51, 32'h404, 32'h40, 32'h1, 32'h0, 1'b1, 1'b1, bub());
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, bub());
        pop_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
